// File: rtl/button_debounce_if.sv
// Push-button conditioning bus.
//   button_in     : raw, asynchronous, bouncing, active-high push-button
//   button_level  : debounced level
//   press_pulse   : one-cycle pulse per accepted press
//   release_pulse : one-cycle pulse per accepted release
//   nxt_pulse     : press pulse OR auto-repeat pulse (display "advance message")
// master drives the button and observes the outputs; slave is the debouncer.
interface button_debounce_if;
  logic button_in;
  logic button_level;
  logic press_pulse;
  logic release_pulse;
  logic nxt_pulse;

  modport master (output button_in,
                  input  button_level, press_pulse, release_pulse, nxt_pulse);
  modport slave  (input  button_in,
                  output button_level, press_pulse, release_pulse, nxt_pulse);
endinterface

// File: rtl/button_debounce.sv
// Conditions a raw bouncing push-button: 2-FF synchroniser, debounce FSM,
// registered press/release pulses, debounced level and optional hold-to-repeat.
// Ports:
//   fpga_clk : system clock, rising edge
//   reset    : synchronous, active-high, highest priority
//   bus      : button_debounce_if.slave (button_in in; level/pulses out)
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 25
) (
  input  logic               fpga_clk,
  input  logic               reset,
  button_debounce_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  localparam logic [CNT_W-1:0] DB_MAX     = CNT_W'(DEBOUNCE_CYCLES);
  // Repeat counter counts HELD edges from 0; the pulse fires on the edge where
  // it would reach the interval, so compare against interval-1.
  localparam logic [CNT_W-1:0] REP_DLY_M1 = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PER_M1 = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;  // still waiting for first repeat of this hold
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             nxt_q, nxt_d;
  logic             rep_hit;

  // State register, counters, synchroniser and registered outputs
  always_ff @(posedge fpga_clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      nxt_q       <= 1'b0;
    end else begin
      sync1_q     <= bus.button_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      nxt_q       <= nxt_d;
    end
  end

  // Repeat fires only while held with the button still seen high; it can never
  // coincide with a press, which happens on the PRESS_WAIT->HELD edge.
  always_comb begin
    rep_hit = 1'b0;
    if (REPEAT_EN != 0 && state_q == HELD && sync2_q)
      rep_hit = (rep_cnt_q == (rep_first_q ? REP_DLY_M1 : REP_PER_M1));
  end

  // Next-state and counter logic
  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = CNT_W'(1);
        end else begin
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_d     = HELD;
          db_cnt_d    = '0;
          rep_cnt_d   = '0;
          rep_first_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = CNT_W'(1);
        end else if (REPEAT_EN != 0) begin
          if (rep_hit) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q + CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        // Repeat counter is left untouched so a bounce resumes the hold timing.
        if (sync2_q) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  // Output logic (registered next cycle)
  always_comb begin
    press_d   = (state_q == PRESS_WAIT) && sync2_q && (db_cnt_q == DB_MAX);
    release_d = (state_q == RELEASE_WAIT) && !sync2_q && (db_cnt_q == DB_MAX);
    level_d   = (state_d == HELD) || (state_d == RELEASE_WAIT);
    nxt_d     = press_d | rep_hit;
  end

  assign bus.button_level  = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.nxt_pulse     = nxt_q;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  button_debounce_if bif0();
  button_debounce_if bif1();

  button_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10),
                    .REPEAT_PERIOD(5), .CNT_W(8))
    u_rep (.fpga_clk(clk), .reset(rst0), .bus(bif0.slave));

  button_debounce #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10),
                    .REPEAT_PERIOD(5), .CNT_W(8))
    u_norep (.fpga_clk(clk), .reset(rst1), .bus(bif1.slave));

  typedef struct { bit rst; bit btn; int n; } seg_t;
  typedef struct { logic lvl; logic prs; logic rel; logic nxt; } obs_t;

  localparam int NS = 6;
  localparam int MS = 16;
  localparam int ME = 8;
  // event kinds: 0 press, 1 release, 2 nxt, 3 level rises, 4 level falls
  seg_t seg[NS][MS];
  int   nseg[NS];
  int   which[NS];
  int   ev[NS][5][ME];
  int   nev[NS][5];
  obs_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  function void add_seg(int s, bit r, bit b, int n);
    seg[s][nseg[s]] = '{r, b, n};
    nseg[s]++;
  endfunction

  function void add_ev(int s, int kind, int e);
    ev[s][kind][nev[s][kind]] = e;
    nev[s][kind]++;
  endfunction

  // every scenario starts with 2 reset edges then 3 idle edges (edges 0..4)
  function void prefix(int s);
    add_seg(s, 1'b1, 1'b0, 2);
    add_seg(s, 1'b0, 1'b0, 3);
  endfunction

  function automatic bit has(int s, int kind, int k);
    for (int i = 0; i < nev[s][kind]; i++)
      if (ev[s][kind][i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string nm, int s, int k, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL scn%0d edge%0d %s: got %b want %b", s, k, nm, act, exp);
    end
  endtask

  initial begin
    obs_t e, a;
    int   k;
    bit   lvl;
    rst0 = 1'b1; rst1 = 1'b1;
    bif0.button_in = 1'b0; bif1.button_in = 1'b0;
    for (int s = 0; s < NS; s++) begin
      nseg[s] = 0; which[s] = 0;
      for (int j = 0; j < 5; j++) nev[s][j] = 0;
    end

    // 0: reset held 3 edges with button high, then press 6 edges after release of reset
    add_seg(0, 1'b1, 1'b1, 3); add_seg(0, 1'b0, 1'b1, 10); add_seg(0, 1'b0, 1'b0, 8);
    add_ev(0, 0, 9); add_ev(0, 2, 9); add_ev(0, 3, 9); add_ev(0, 1, 19); add_ev(0, 4, 19);
    // 1: plain hold with auto-repeat, then release
    prefix(1); add_seg(1, 1'b0, 1'b1, 28); add_seg(1, 1'b0, 1'b0, 10);
    add_ev(1, 0, 11); add_ev(1, 3, 11);
    add_ev(1, 2, 11); add_ev(1, 2, 21); add_ev(1, 2, 26); add_ev(1, 2, 31);
    add_ev(1, 1, 39); add_ev(1, 4, 39);
    // 2: bounce 1,1,1,0 x5, then steady press
    prefix(2);
    for (int i = 0; i < 5; i++) begin
      add_seg(2, 1'b0, 1'b1, 3); add_seg(2, 1'b0, 1'b0, 1);
    end
    add_seg(2, 1'b0, 1'b1, 12); add_seg(2, 1'b0, 1'b0, 10);
    add_ev(2, 0, 31); add_ev(2, 2, 31); add_ev(2, 3, 31); add_ev(2, 1, 43); add_ev(2, 4, 43);
    // 3: 2-cycle release bounce mid-hold freezes the repeat timer (first repeat slips 3 edges)
    prefix(3); add_seg(3, 1'b0, 1'b1, 12); add_seg(3, 1'b0, 1'b0, 2);
    add_seg(3, 1'b0, 1'b1, 10); add_seg(3, 1'b0, 1'b0, 10);
    add_ev(3, 0, 11); add_ev(3, 3, 11);
    add_ev(3, 2, 11); add_ev(3, 2, 24); add_ev(3, 2, 29);
    add_ev(3, 1, 35); add_ev(3, 4, 35);
    // 4: reset during HELD with the button kept high
    prefix(4); add_seg(4, 1'b0, 1'b1, 14); add_seg(4, 1'b1, 1'b1, 2);
    add_seg(4, 1'b0, 1'b1, 10); add_seg(4, 1'b0, 1'b0, 10);
    add_ev(4, 0, 11); add_ev(4, 2, 11); add_ev(4, 3, 11); add_ev(4, 4, 19);
    add_ev(4, 0, 27); add_ev(4, 2, 27); add_ev(4, 3, 27);
    add_ev(4, 1, 37); add_ev(4, 4, 37);
    // 5: repeat disabled, long hold -> single nxt pulse
    which[5] = 1;
    prefix(5); add_seg(5, 1'b0, 1'b1, 40); add_seg(5, 1'b0, 1'b0, 10);
    add_ev(5, 0, 11); add_ev(5, 2, 11); add_ev(5, 3, 11); add_ev(5, 1, 51); add_ev(5, 4, 51);

    repeat (3) @(posedge clk);
    for (int s = 0; s < NS; s++) begin
      k = 0; lvl = 1'b0;
      for (int g = 0; g < nseg[s]; g++) begin
        for (int c = 0; c < seg[s][g].n; c++) begin
          @(negedge clk);
          if (which[s] == 0) begin
            rst0 = seg[s][g].rst; bif0.button_in = seg[s][g].btn;
            rst1 = 1'b1;          bif1.button_in = 1'b0;
          end else begin
            rst1 = seg[s][g].rst; bif1.button_in = seg[s][g].btn;
            rst0 = 1'b1;          bif0.button_in = 1'b0;
          end
          if (has(s, 3, k)) lvl = 1'b1;
          if (has(s, 4, k)) lvl = 1'b0;
          e.lvl = lvl;
          e.prs = has(s, 0, k);
          e.rel = has(s, 1, k);
          e.nxt = has(s, 2, k);
          sbq.push_back(e);
          @(posedge clk); #1;
          if (which[s] == 0)
            a = '{bif0.button_level, bif0.press_pulse, bif0.release_pulse, bif0.nxt_pulse};
          else
            a = '{bif1.button_level, bif1.press_pulse, bif1.release_pulse, bif1.nxt_pulse};
          e = sbq.pop_front();
          chk("button_level",  s, k, a.lvl, e.lvl);
          chk("press_pulse",   s, k, a.prs, e.prs);
          chk("release_pulse", s, k, a.rel, e.rel);
          chk("nxt_pulse",     s, k, a.nxt, e.nxt);
          k++;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
